udp_test_frame_gen: RTL and testbench
=====================================

// Module: udp_test_frame_gen
// PURPOSE
//  Master-side UDP test traffic source for the host network stack bench. Drives the UDP TX
//  header channel (112-bit packed header) and the 64-bit AXI-Stream payload channel of the
//  UDP stack. Emits a configured number of frames with a deterministic, self-checkable payload.
//  A sink on the far end of the link verifies the payload pattern.
// PARAMETERS
//  MAX_PAYLOAD   1472  largest accepted payload length in bytes (one 1500-byte MTU frame)
//  IFG_CYCLES    4     idle clk cycles between tlast handshake and next header valid (0 allowed)
// PORTS
//  clk                     in   1    single clock domain
//  rst_n                   in   1    asynchronous, active-low reset
//  start                   in   1    1-cycle pulse; latches all cfg_* inputs, begins a run
//  stop                    in   1    level; ends the run after the current frame completes
//  cfg_src_ip/cfg_dst_ip   in   32   IPv4 addresses placed in the header
//  cfg_src_port/dst_port   in   16   UDP ports placed in the header
//  cfg_payload_len         in   16   payload bytes per frame, 1..MAX_PAYLOAD
//  cfg_frame_count         in   32   frames per run; 0 = continuous until stop
//  m_udp_hdr_valid         out  1    header valid
//  m_udp_hdr_ready         in   1    header accepted by stack
//  m_udp_hdr_data          out  112  {src_ip, dst_ip, src_port, dst_port, udp_length}
//  m_udp_payload_axis_tdata/tkeep/tvalid/tlast/tuser  out 64/8/1/1/1 ; _tready in 1
//  busy                    out  1    high from accepted start until DONE
//  done                    out  1    1-cycle pulse when run ends
//  cfg_err                 out  1    1-cycle pulse: start rejected (bad payload length)
//  frames_sent             out  32   frames whose tlast was accepted in the current run
// BEHAVIOUR
//  - Reset (async, rst_n low): state IDLE; all outputs 0; counters 0. Deassertion is synchronous.
//  - States: IDLE -> HDR -> PAY -> GAP -> HDR ... -> DONE -> IDLE.
//  - IDLE: start with len in 1..MAX_PAYLOAD latches cfg, clears frames_sent, -> HDR; hdr_valid
//    rises the cycle after start. Start with len 0 or >MAX_PAYLOAD: cfg_err pulse, stay IDLE.
//    start while not IDLE is ignored.
//  - udp_length = cfg_payload_len + 8 (16-bit; MAX_PAYLOAD guarantees no overflow).
//  - HDR: hdr_valid held with stable data until hdr_ready; on handshake -> PAY; payload tvalid
//    rises the next cycle. Header and payload are never valid together.
//  - PAY: beat k (0-based) of frame f: tdata = {f[31:0], k[31:0]}; beats = ceil(len/8).
//    tlast on beat beats-1; tkeep = 8'hFF except last beat = (8'h01<<(len%8))-1, 8'hFF if len%8==0.
//    tuser always 0. tdata/tkeep/tlast held stable while tvalid && !tready (AXIS rules).
//  - tlast handshake: frames_sent++ same edge. If stop high, or frames_sent+1 == cfg_frame_count
//    (count != 0): -> DONE. Else -> GAP (or straight to HDR if IFG_CYCLES == 0).
//  - GAP: count IFG_CYCLES cycles, then -> HDR with f incremented. f wraps at 2^32.
//  - stop asserted in HDR before handshake: hdr_valid dropped, -> DONE, no frame sent.
//    stop in PAY: frame finishes normally (never truncated). stop in GAP: -> DONE next cycle.
//  - DONE: done=1 for one cycle, busy=0, -> IDLE. frames_sent holds until next accepted start.
//  - Reset mid-frame: outputs go to 0 immediately; partial frame is abandoned.
// STRUCTURE
//  - Shared header udp_tgen_defs.vh: state encodings, UDP_HDR_W=112, header field bit offsets
//    (src_ip [111:80], dst_ip [79:48], src_port [47:32], dst_port [31:16], length [15:0]).
//  - No sub-module; last-beat tkeep and beat count are local functions. Single FSM + 3 counters
//    (beat, frame, gap). Est. 200-260 lines.
// TESTING
//  1 len=64,count=1,ready=1: hdr length=72; 8 beats tkeep FF, beat3 = 64'h00000000_00000003; done.
//  2 len=13,count=2,IFG=4: 2 beats/frame, last tkeep 8'h1F; exactly 4 idle cycles between frames;
//    frame 1 beat 0 = 64'h00000001_00000000; frames_sent=2.
//  3 random tready/hdr_ready backpressure, len=1473 then 1472: first -> cfg_err, no valid;
//    second -> 184 beats, data stable under stall, last tkeep FF.
//  4 count=0, stop raised mid-PAY of frame 5: frame 5 completes with tlast, done, frames_sent=6.
//  5 rst_n low mid-PAY: all valids 0 same cycle; after release, start yields fresh frame 0.
//  6 stop during HDR (hdr_ready held 0): hdr_valid drops, done pulse, frames_sent unchanged.

Source files
------------

// File: rtl/udp_test_frame_gen_pkg.sv
// rtl/udp_test_frame_gen_pkg.sv - shared types, header layout and beat helpers for the UDP test frame generator
package udp_test_frame_gen_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_HDR  = 3'd1,
        ST_PAY  = 3'd2,
        ST_GAP  = 3'd3,
        ST_DONE = 3'd4
    } state_t;

    localparam int UDP_HDR_W   = 112;
    localparam int SRC_IP_LSB  = 80;
    localparam int DST_IP_LSB  = 48;
    localparam int SRC_PRT_LSB = 32;
    localparam int DST_PRT_LSB = 16;
    localparam int LEN_LSB     = 0;

    function automatic logic [15:0] beat_count(input logic [15:0] len);
        logic [16:0] sum;
        sum = {1'b0, len} + 17'd7;
        return {2'b00, sum[16:3]};
    endfunction

    // A partial final beat keeps only the low len%8 byte lanes.
    function automatic logic [7:0] last_keep(input logic [15:0] len);
        if (len[2:0] == 3'd0) begin
            return 8'hFF;
        end
        return (8'h01 << len[2:0]) - 8'h01;
    endfunction

endpackage

// File: rtl/udp_test_frame_gen.sv
// rtl/udp_test_frame_gen.sv - UDP header plus deterministic payload test traffic source
module udp_test_frame_gen
    import udp_test_frame_gen_pkg::*;
#(
    parameter int MAX_PAYLOAD = 1472,
    parameter int IFG_CYCLES  = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic                 stop,
    input  logic [31:0]          cfg_src_ip,
    input  logic [31:0]          cfg_dst_ip,
    input  logic [15:0]          cfg_src_port,
    input  logic [15:0]          cfg_dst_port,
    input  logic [15:0]          cfg_payload_len,
    input  logic [31:0]          cfg_frame_count,
    output logic                 m_udp_hdr_valid,
    input  logic                 m_udp_hdr_ready,
    output logic [UDP_HDR_W-1:0] m_udp_hdr_data,
    output logic [63:0]          m_udp_payload_axis_tdata,
    output logic [7:0]           m_udp_payload_axis_tkeep,
    output logic                 m_udp_payload_axis_tvalid,
    output logic                 m_udp_payload_axis_tlast,
    output logic                 m_udp_payload_axis_tuser,
    input  logic                 m_udp_payload_axis_tready,
    output logic                 busy,
    output logic                 done,
    output logic                 cfg_err,
    output logic [31:0]          frames_sent
);

    localparam logic [15:0] MAX_LEN  = 16'(MAX_PAYLOAD);
    localparam logic [15:0] GAP_LAST = 16'(IFG_CYCLES - 1);

    state_t      state, state_nxt;
    logic [31:0] src_ip_q, dst_ip_q, count_q, frame_idx, frames_sent_q;
    logic [15:0] src_port_q, dst_port_q, len_q, beats_q, beat_cnt, gap_cnt;
    logic        cfg_err_q;
    logic        len_ok, start_ok, hdr_hs, pay_hs, last_beat, run_end;

    assign len_ok    = (cfg_payload_len != 16'd0) && (cfg_payload_len <= MAX_LEN);
    assign start_ok  = (state == ST_IDLE) && start && len_ok;
    assign hdr_hs    = (state == ST_HDR) && m_udp_hdr_ready;
    assign pay_hs    = (state == ST_PAY) && m_udp_payload_axis_tready;
    assign last_beat = (beat_cnt == beats_q - 16'd1);
    assign run_end   = stop || ((count_q != 32'd0) && (frames_sent_q + 32'd1 == count_q));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (start_ok) state_nxt = ST_HDR;
            // A header already being accepted wins over stop: the frame then runs to completion.
            ST_HDR: begin
                if (m_udp_hdr_ready) state_nxt = ST_PAY;
                else if (stop)       state_nxt = ST_DONE;
            end
            ST_PAY: begin
                if (pay_hs && last_beat) begin
                    if (run_end)              state_nxt = ST_DONE;
                    else if (IFG_CYCLES == 0) state_nxt = ST_HDR;
                    else                      state_nxt = ST_GAP;
                end
            end
            ST_GAP: begin
                if (stop)                     state_nxt = ST_DONE;
                else if (gap_cnt == GAP_LAST) state_nxt = ST_HDR;
            end
            ST_DONE: state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            src_ip_q      <= '0;
            dst_ip_q      <= '0;
            src_port_q    <= '0;
            dst_port_q    <= '0;
            len_q         <= '0;
            count_q       <= '0;
            beats_q       <= '0;
            beat_cnt      <= '0;
            gap_cnt       <= '0;
            frame_idx     <= '0;
            frames_sent_q <= '0;
            cfg_err_q     <= 1'b0;
        end else begin
            cfg_err_q <= (state == ST_IDLE) && start && !len_ok;
            if (start_ok) begin
                src_ip_q      <= cfg_src_ip;
                dst_ip_q      <= cfg_dst_ip;
                src_port_q    <= cfg_src_port;
                dst_port_q    <= cfg_dst_port;
                len_q         <= cfg_payload_len;
                count_q       <= cfg_frame_count;
                beats_q       <= beat_count(cfg_payload_len);
                frame_idx     <= '0;
                frames_sent_q <= '0;
            end
            if (hdr_hs) begin
                beat_cnt <= '0;
            end
            if (pay_hs) begin
                beat_cnt <= beat_cnt + 16'd1;
                if (last_beat) begin
                    frames_sent_q <= frames_sent_q + 32'd1;
                end
            end
            gap_cnt <= (state == ST_GAP) ? gap_cnt + 16'd1 : 16'd0;
            if ((state_nxt == ST_HDR) && ((state == ST_GAP) || (state == ST_PAY))) begin
                frame_idx <= frame_idx + 32'd1;
            end
        end
    end

    // Channel outputs are zeroed whenever their valid is low so nothing stale leaks out.
    always_comb begin
        m_udp_hdr_valid           = 1'b0;
        m_udp_hdr_data            = '0;
        m_udp_payload_axis_tvalid = 1'b0;
        m_udp_payload_axis_tdata  = '0;
        m_udp_payload_axis_tkeep  = '0;
        m_udp_payload_axis_tlast  = 1'b0;
        m_udp_payload_axis_tuser  = 1'b0;
        busy                      = (state == ST_HDR) || (state == ST_PAY) || (state == ST_GAP);
        done                      = (state == ST_DONE);
        cfg_err                   = cfg_err_q;
        frames_sent               = frames_sent_q;
        case (state)
            ST_HDR: begin
                m_udp_hdr_valid                          = 1'b1;
                m_udp_hdr_data[SRC_IP_LSB +: 32]  = src_ip_q;
                m_udp_hdr_data[DST_IP_LSB +: 32]  = dst_ip_q;
                m_udp_hdr_data[SRC_PRT_LSB +: 16] = src_port_q;
                m_udp_hdr_data[DST_PRT_LSB +: 16] = dst_port_q;
                m_udp_hdr_data[LEN_LSB +: 16]     = len_q + 16'd8;
            end
            ST_PAY: begin
                m_udp_payload_axis_tvalid = 1'b1;
                m_udp_payload_axis_tdata  = {frame_idx, 16'd0, beat_cnt};
                m_udp_payload_axis_tkeep  = last_beat ? last_keep(len_q) : 8'hFF;
                m_udp_payload_axis_tlast  = last_beat;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_udp_test_frame_gen.sv
// tb/tb_udp_test_frame_gen.sv - directed self-checking bench for udp_test_frame_gen
module tb_udp_test_frame_gen;

    localparam logic [31:0] SRC = 32'hC0A8_0001;
    localparam logic [31:0] DST = 32'hC0A8_0002;
    localparam logic [15:0] SP  = 16'h1234;
    localparam logic [15:0] DP  = 16'h5678;

    logic         clk = 1'b0;
    logic         rst_n, start, stop;
    logic [31:0]  cfg_src_ip, cfg_dst_ip, cfg_frame_count;
    logic [15:0]  cfg_src_port, cfg_dst_port, cfg_payload_len;
    logic         hdr_valid, hdr_ready;
    logic [111:0] hdr_data;
    logic [63:0]  tdata;
    logic [7:0]   tkeep;
    logic         tvalid, tlast, tuser, tready;
    logic         busy, done, cfg_err;
    logic [31:0]  frames_sent;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    udp_test_frame_gen #(.MAX_PAYLOAD(1472), .IFG_CYCLES(4)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .stop(stop),
        .cfg_src_ip(cfg_src_ip), .cfg_dst_ip(cfg_dst_ip),
        .cfg_src_port(cfg_src_port), .cfg_dst_port(cfg_dst_port),
        .cfg_payload_len(cfg_payload_len), .cfg_frame_count(cfg_frame_count),
        .m_udp_hdr_valid(hdr_valid), .m_udp_hdr_ready(hdr_ready), .m_udp_hdr_data(hdr_data),
        .m_udp_payload_axis_tdata(tdata), .m_udp_payload_axis_tkeep(tkeep),
        .m_udp_payload_axis_tvalid(tvalid), .m_udp_payload_axis_tlast(tlast),
        .m_udp_payload_axis_tuser(tuser), .m_udp_payload_axis_tready(tready),
        .busy(busy), .done(done), .cfg_err(cfg_err), .frames_sent(frames_sent)
    );

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic start_run(input logic [15:0] len, input logic [31:0] cnt);
        cfg_payload_len = len;
        cfg_frame_count = cnt;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Waits for and accepts one header, then consumes the whole payload, checking every presented beat.
    task automatic frame(input logic [31:0] f, input int len, input bit rnd, input int stop_at);
        int beats;
        int k;
        int t;
        bit r;
        logic [7:0] kexp;
        beats = (len + 7) / 8;
        t = 0;
        while (!hdr_valid && t < 200) begin
            @(negedge clk);
            t++;
        end
        chk("hdr_wait", hdr_valid, 1'b1);
        r = 1'b0;
        while (!r && t < 2000) begin
            chk("hdr_data", hdr_data, {SRC, DST, SP, DP, 16'(len + 8)});
            chk("hdr_excl", tvalid, 1'b0);
            r = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            hdr_ready = r;
            @(negedge clk);
            t++;
        end
        k = 0;
        while (k < beats && t < 20000) begin
            if (k == stop_at) stop = 1'b1;
            kexp = (k == beats - 1 && len % 8 != 0) ? 8'((1 << (len % 8)) - 1) : 8'hFF;
            chk("tvalid", tvalid, 1'b1);
            chk("tdata", tdata, {f, 32'(k)});
            chk("tkeep", tkeep, kexp);
            chk("tlast", tlast, (k == beats - 1));
            chk("tuser", tuser, 1'b0);
            chk("pay_excl", hdr_valid, 1'b0);
            r = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            tready = r;
            @(negedge clk);
            t++;
            if (r) k++;
        end
        chk("frame_beats", k, beats);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int g;
        rst_n = 1'b0; start = 1'b0; stop = 1'b0;
        hdr_ready = 1'b1; tready = 1'b1;
        cfg_src_ip = SRC; cfg_dst_ip = DST; cfg_src_port = SP; cfg_dst_port = DP;
        cfg_payload_len = 16'd0; cfg_frame_count = 32'd0;
        repeat (3) @(negedge clk);
        chk("rst_outs", {hdr_valid, tvalid, busy, done, cfg_err}, 5'b0);
        chk("rst_frames", frames_sent, 32'd0);
        chk("rst_hdr", hdr_data, 112'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // 1: single 64-byte frame, no backpressure
        start_run(16'd64, 32'd1);
        chk("t1_busy", busy, 1'b1);
        frame(32'd0, 64, 1'b0, -1);
        chk("t1_done", done, 1'b1);
        chk("t1_busy_done", busy, 1'b0);
        chk("t1_sent", frames_sent, 32'd1);
        @(negedge clk);
        chk("t1_done_pulse", done, 1'b0);

        // 2: two 13-byte frames with a 4-cycle gap
        start_run(16'd13, 32'd2);
        frame(32'd0, 13, 1'b0, -1);
        g = 0;
        while (!hdr_valid && g < 50) begin
            chk("t2_gap_idle", tvalid, 1'b0);
            @(negedge clk);
            g++;
        end
        chk("t2_gap", g, 4);
        frame(32'd1, 13, 1'b0, -1);
        chk("t2_done", done, 1'b1);
        chk("t2_sent", frames_sent, 32'd2);
        @(negedge clk);

        // 3: bad length rejected, then max length under random backpressure
        start_run(16'd1473, 32'd1);
        chk("t3_err", cfg_err, 1'b1);
        chk("t3_noval", {hdr_valid, tvalid, busy}, 3'b0);
        @(negedge clk);
        chk("t3_err_pulse", cfg_err, 1'b0);
        chk("t3_idle", {hdr_valid, busy}, 2'b0);
        start_run(16'd1472, 32'd1);
        frame(32'd0, 1472, 1'b1, -1);
        chk("t3_done", done, 1'b1);
        hdr_ready = 1'b1; tready = 1'b1;
        @(negedge clk);

        // 4: continuous run, stop raised mid-payload of frame 5
        start_run(16'd24, 32'd0);
        for (int f = 0; f < 5; f++) frame(32'(f), 24, 1'b0, -1);
        frame(32'd5, 24, 1'b0, 1);
        chk("t4_done", done, 1'b1);
        chk("t4_sent", frames_sent, 32'd6);
        stop = 1'b0;
        @(negedge clk);
        chk("t4_idle", {busy, done}, 2'b0);

        // 5: reset in the middle of a payload
        start_run(16'd64, 32'd0);
        g = 0;
        while (!tvalid && g < 50) begin
            @(negedge clk);
            g++;
        end
        chk("t5_in_pay", tvalid, 1'b1);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("t5_rst_valids", {hdr_valid, tvalid, busy}, 3'b0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        start_run(16'd16, 32'd1);
        frame(32'd0, 16, 1'b0, -1);
        chk("t5_done", done, 1'b1);
        chk("t5_sent", frames_sent, 32'd1);
        @(negedge clk);

        // 6: stop while a header is stalled
        start_run(16'd8, 32'd0);
        frame(32'd0, 8, 1'b0, -1);
        frame(32'd1, 8, 1'b0, -1);
        hdr_ready = 1'b0;
        g = 0;
        while (!hdr_valid && g < 50) begin
            @(negedge clk);
            g++;
        end
        repeat (2) @(negedge clk);
        chk("t6_hdr_held", hdr_valid, 1'b1);
        stop = 1'b1;
        @(negedge clk);
        chk("t6_hdr_drop", hdr_valid, 1'b0);
        chk("t6_done", done, 1'b1);
        chk("t6_sent", frames_sent, 32'd2);
        stop = 1'b0;
        @(negedge clk);
        chk("t6_idle", {busy, done, hdr_valid}, 3'b0);
        chk("t6_sent_hold", frames_sent, 32'd2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
